// File: rtl/safe_vault_pkg.sv
// Shared types and defaults for the safe vault keypad front end.
package safe_vault_pkg;

    typedef enum logic [2:0] {
        IDLE,
        COLLECT,
        FULL,
        SEND,
        HOLD
    } entry_state_t;

    localparam int PSW_W       = 16;
    localparam int DIGITS_DEF  = PSW_W / 4;
    localparam int TIMEOUT_DEF = 5;   // matches the vault countdown window
    localparam int HOLD_DEF    = 4;

endpackage

// File: rtl/keypad_entry_tick_counter.sv
// Loadable saturating up-counter; term flags the enabled step that reaches LIMIT.
module tick_counter #(
    parameter int LIMIT = 5,
    parameter int W     = $clog2(LIMIT + 1)
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         clear,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         enable,
    output logic         term
);

    localparam logic [W-1:0] LAST = W'(LIMIT - 1);
    localparam logic [W-1:0] TOP  = W'(LIMIT);

    logic [W-1:0] count;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (enable && count != TOP) begin
            count <= count + W'(1);
        end
    end

    // Flag is combinational so the owner can act on the same edge the limit is hit.
    assign term = enable && (count == LAST);

endmodule

// File: rtl/keypad_entry.sv
// Keypad front end: assembles hex digits into a passcode, strobes it out, and
// aborts the attempt after a period of inactivity.
module keypad_entry
    import safe_vault_pkg::*;
#(
    parameter int DIGITS    = DIGITS_DEF,
    parameter int TIMEOUT_S = TIMEOUT_DEF,
    parameter int HOLD_CYC  = HOLD_DEF
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                key_valid,
    input  logic [3:0]          key_code,
    input  logic                key_clear,
    input  logic                key_enter,
    input  logic                sec_tick,
    output logic [4*DIGITS-1:0] passcode,
    output logic                Enter_PSW,
    output logic                CT_DN,
    output logic [2:0]          digit_cnt,
    output logic                busy,
    output logic                reject,
    output logic                abort
);

    localparam int         PW       = 4 * DIGITS;
    localparam logic [2:0] CNT_FULL = 3'(DIGITS);

    entry_state_t state, state_nxt;

    logic [PW-1:0] passcode_nxt, shifted;
    logic [2:0]    cnt_nxt;
    logic          enter_nxt, ct_dn_nxt, reject_nxt, abort_nxt, busy_nxt;
    logic          in_entry, key_taken, tmo_en, tmo_clear, timed_out;
    logic          hold_en, hold_clear, hold_done;

    // Any key that wins arbitration in an entry state restarts the inactivity window.
    assign in_entry   = (state == COLLECT) || (state == FULL);
    assign key_taken  = key_clear || key_enter || (key_valid && state == COLLECT);
    assign tmo_en     = in_entry && sec_tick && !key_taken;
    assign tmo_clear  = !in_entry || key_taken;
    assign hold_en    = (state == HOLD);
    assign hold_clear = !hold_en;
    assign shifted    = (passcode << 4) | PW'(key_code);

    tick_counter #(.LIMIT(TIMEOUT_S)) u_timeout (
        .clk      (clk),
        .reset_n  (reset_n),
        .clear    (tmo_clear),
        .load     (1'b0),
        .load_val ('0),
        .enable   (tmo_en),
        .term     (timed_out)
    );

    tick_counter #(.LIMIT(HOLD_CYC)) u_hold (
        .clk      (clk),
        .reset_n  (reset_n),
        .clear    (hold_clear),
        .load     (1'b0),
        .load_val ('0),
        .enable   (hold_en),
        .term     (hold_done)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            passcode  <= '0;
            digit_cnt <= '0;
            Enter_PSW <= 1'b0;
            CT_DN     <= 1'b0;
            busy      <= 1'b0;
            reject    <= 1'b0;
            abort     <= 1'b0;
        end else begin
            state     <= state_nxt;
            passcode  <= passcode_nxt;
            digit_cnt <= cnt_nxt;
            Enter_PSW <= enter_nxt;
            CT_DN     <= ct_dn_nxt;
            busy      <= busy_nxt;
            reject    <= reject_nxt;
            abort     <= abort_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (key_valid) state_nxt = (CNT_FULL == 3'd1) ? FULL : COLLECT;
            end
            COLLECT: begin
                if (key_clear)                            state_nxt = IDLE;
                else if (key_enter)                       state_nxt = COLLECT;
                else if (key_valid)                       state_nxt = (digit_cnt + 3'd1 == CNT_FULL) ? FULL : COLLECT;
                else if (timed_out)                       state_nxt = IDLE;
            end
            FULL: begin
                if (key_clear)      state_nxt = IDLE;
                else if (key_enter) state_nxt = SEND;
                else if (timed_out) state_nxt = IDLE;
            end
            SEND:    state_nxt = HOLD;
            HOLD:    if (hold_done) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        passcode_nxt = passcode;
        cnt_nxt      = digit_cnt;
        enter_nxt    = 1'b0;
        ct_dn_nxt    = 1'b0;
        reject_nxt   = 1'b0;
        abort_nxt    = 1'b0;
        busy_nxt     = (state_nxt != IDLE);
        case (state)
            IDLE: begin
                if (key_valid) begin
                    passcode_nxt = shifted;
                    cnt_nxt      = 3'd1;
                    ct_dn_nxt    = 1'b1;
                end
            end
            COLLECT: begin
                if (key_clear) begin
                    passcode_nxt = '0;
                    cnt_nxt      = '0;
                end else if (key_enter) begin
                    reject_nxt = 1'b1;
                end else if (key_valid) begin
                    passcode_nxt = shifted;
                    cnt_nxt      = digit_cnt + 3'd1;
                end else if (timed_out) begin
                    passcode_nxt = '0;
                    cnt_nxt      = '0;
                    abort_nxt    = 1'b1;
                end
            end
            FULL: begin
                if (key_clear) begin
                    passcode_nxt = '0;
                    cnt_nxt      = '0;
                end else if (key_enter) begin
                    enter_nxt = 1'b1;
                end else if (timed_out) begin
                    passcode_nxt = '0;
                    cnt_nxt      = '0;
                    abort_nxt    = 1'b1;
                end
            end
            HOLD: begin
                if (hold_done) begin
                    passcode_nxt = '0;
                    cnt_nxt      = '0;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_keypad_entry.sv
// Randomized and directed bench for keypad_entry against a digit-queue reference model.
module tb_keypad_entry;

    localparam int DIGITS    = 4;
    localparam int TIMEOUT_S = 5;
    localparam int HOLD_CYC  = 4;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        key_valid = 1'b0;
    logic [3:0]  key_code = 4'h0;
    logic        key_clear = 1'b0;
    logic        key_enter = 1'b0;
    logic        sec_tick = 1'b0;
    logic [15:0] passcode;
    logic        Enter_PSW, CT_DN, busy, reject, abort;
    logic [2:0]  digit_cnt;

    keypad_entry #(.DIGITS(DIGITS), .TIMEOUT_S(TIMEOUT_S), .HOLD_CYC(HOLD_CYC)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .key_valid (key_valid),
        .key_code  (key_code),
        .key_clear (key_clear),
        .key_enter (key_enter),
        .sec_tick  (sec_tick),
        .passcode  (passcode),
        .Enter_PSW (Enter_PSW),
        .CT_DN     (CT_DN),
        .digit_cnt (digit_cnt),
        .busy      (busy),
        .reject    (reject),
        .abort     (abort)
    );

    always #5 clk = ~clk;

    // Reference model: entered digits, inactivity ticks, remaining stable cycles after submit.
    int q[$];
    int timer = 0;
    int send_left = 0;
    bit m_ct, m_ent, m_rej, m_abt;

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_code();
        logic [31:0] p = 32'h0;
        foreach (q[i]) p = (p << 4) | 32'(q[i]);
        return p;
    endfunction

    task automatic model_reset();
        q.delete();
        timer = 0;
        send_left = 0;
        m_ct = 0; m_ent = 0; m_rej = 0; m_abt = 0;
    endtask

    task automatic model_step();
        m_ct = 0; m_ent = 0; m_rej = 0; m_abt = 0;
        if (!reset_n) begin
            model_reset();
        end else if (send_left > 0) begin
            send_left--;
            if (send_left == 0) q.delete();
        end else if (q.size() == 0) begin
            if (key_valid) begin
                q.push_back(int'(key_code));
                m_ct = 1;
                timer = 0;
            end
        end else if (key_clear) begin
            q.delete();
            timer = 0;
        end else if (key_enter) begin
            timer = 0;
            if (q.size() < DIGITS) m_rej = 1;
            else begin
                m_ent = 1;
                send_left = HOLD_CYC + 1;
            end
        end else if (key_valid && q.size() < DIGITS) begin
            q.push_back(int'(key_code));
            timer = 0;
        end else if (sec_tick) begin
            timer++;
            if (timer == TIMEOUT_S) begin
                m_abt = 1;
                q.delete();
                timer = 0;
            end
        end
    endtask

    task automatic check_all();
        chk("passcode",  32'(passcode),  model_code());
        chk("digit_cnt", 32'(digit_cnt), 32'(q.size()));
        chk("Enter_PSW", 32'(Enter_PSW), 32'(m_ent));
        chk("CT_DN",     32'(CT_DN),     32'(m_ct));
        chk("busy",      32'(busy),      (send_left > 0 || q.size() > 0) ? 32'd1 : 32'd0);
        chk("reject",    32'(reject),    32'(m_rej));
        chk("abort",     32'(abort),     32'(m_abt));
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        #1 check_all();
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic press(input logic [3:0] d);
        key_valid = 1'b1;
        key_code  = d;
        step();
        key_valid = 1'b0;
    endtask

    task automatic enter();
        key_enter = 1'b1;
        step();
        key_enter = 1'b0;
    endtask

    task automatic tick();
        sec_tick = 1'b1;
        step();
        sec_tick = 1'b0;
    endtask

    initial begin
        #2 model_reset();
        check_all();
        chk("reset_passcode", 32'(passcode), 32'h0);
        idle(2);
        reset_n = 1'b1;
        idle(2);

        // Correct code E469
        press(4'hE);
        chk("ct_dn_first", 32'(CT_DN), 32'd1);
        press(4'h4);
        chk("ct_dn_once", 32'(CT_DN), 32'd0);
        press(4'h6);
        press(4'h9);
        chk("cnt_full", 32'(digit_cnt), 32'd4);
        enter();
        chk("strobe", 32'(Enter_PSW), 32'd1);
        chk("strobe_code", 32'(passcode), 32'hE469);
        idle(4);
        chk("held_code", 32'(passcode), 32'hE469);
        idle(1);
        chk("released_code", 32'(passcode), 32'h0);
        chk("released_busy", 32'(busy), 32'd0);

        // Short entry then overflow
        press(4'h1);
        press(4'h2);
        enter();
        chk("reject_pulse", 32'(reject), 32'd1);
        chk("reject_cnt", 32'(digit_cnt), 32'd2);
        press(4'h3);
        press(4'h4);
        chk("ovf_code", 32'(passcode), 32'h1234);
        press(4'h5);
        chk("ovf_ignored", 32'(passcode), 32'h1234);
        chk("ovf_cnt", 32'(digit_cnt), 32'd4);
        enter();
        chk("ovf_strobe", 32'(Enter_PSW), 32'd1);
        chk("ovf_strobe_code", 32'(passcode), 32'h1234);
        idle(6);

        // Inactivity timeout
        press(4'hA);
        for (int i = 0; i < 4; i++) begin
            tick();
            idle(1);
        end
        chk("no_abort_yet", 32'(abort), 32'd0);
        tick();
        chk("abort_pulse", 32'(abort), 32'd1);
        chk("abort_code", 32'(passcode), 32'h0);
        chk("abort_busy", 32'(busy), 32'd0);
        press(4'h3);
        repeat (4) tick();
        press(4'h4);
        repeat (4) tick();
        chk("gap_no_abort", 32'(busy), 32'd1);
        key_clear = 1'b1;
        step();
        key_clear = 1'b0;

        // Clear beats enter and a digit in FULL
        press(4'h1); press(4'h2); press(4'h3); press(4'h4);
        key_clear = 1'b1; key_enter = 1'b1; key_valid = 1'b1; key_code = 4'h7;
        step();
        key_clear = 1'b0; key_enter = 1'b0; key_valid = 1'b0;
        chk("clr_no_strobe", 32'(Enter_PSW), 32'd0);
        chk("clr_code", 32'(passcode), 32'h0);
        chk("clr_busy", 32'(busy), 32'd0);
        idle(1);

        // Asynchronous reset while holding
        press(4'h9); press(4'h8); press(4'h7); press(4'h6);
        enter();
        idle(2);
        #3 reset_n = 1'b0;
        #1 model_reset();
        check_all();
        chk("async_code", 32'(passcode), 32'h0);
        chk("async_busy", 32'(busy), 32'd0);
        step();
        reset_n = 1'b1;
        press(4'h0); press(4'h0); press(4'h0); press(4'h1);
        enter();
        chk("post_reset_code", 32'(passcode), 32'h0001);
        chk("post_reset_strobe", 32'(Enter_PSW), 32'd1);

        // Keys during HOLD are locked out
        press(4'h7);
        chk("lock_ct_dn", 32'(CT_DN), 32'd0);
        press(4'h8);
        enter();
        chk("lock_code", 32'(passcode), 32'h0001);
        chk("lock_no_strobe", 32'(Enter_PSW), 32'd0);
        idle(2);
        press(4'h5);
        chk("ct_dn_after_idle", 32'(CT_DN), 32'd1);
        key_clear = 1'b1;
        step();
        key_clear = 1'b0;

        // Random traffic
        for (int i = 0; i < 2500; i++) begin
            key_valid = ($urandom_range(0, 99) < 35);
            key_code  = 4'($urandom_range(0, 15));
            key_clear = ($urandom_range(0, 99) < 3);
            key_enter = ($urandom_range(0, 99) < 10);
            sec_tick  = ($urandom_range(0, 99) < 20);
            step();
        end
        key_valid = 1'b0; key_clear = 1'b0; key_enter = 1'b0; sec_tick = 1'b0;
        idle(8);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/keypad_entry.md
# keypad_entry

Keypad front end for the safe vault. It collects hex digits from a debounced keypad into a passcode word and delivers it with a one-cycle enter strobe. It also raises the countdown-start request on the first digit and aborts the attempt on inactivity. It drives the vault's `passcode`, `Enter_PSW` and `CT_DN` inputs.

## Interface
Parameters:
- `DIGITS`, default 4: number of hex digits per passcode.
- `TIMEOUT_S`, default 5: inactivity limit, counted in `sec_tick` pulses.
- `HOLD_CYC`, default 4: cycles the passcode is held after the enter strobe.

Ports:
- `clk` in 1: single clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `key_valid` in 1: one-cycle pulse; `key_code` is a digit.
- `key_code` in 4: hex digit value.
- `key_clear` in 1: one-cycle pulse; discard entry.
- `key_enter` in 1: one-cycle pulse; submit entry.
- `sec_tick` in 1: one-cycle 1 Hz enable.
- `passcode` out 4*DIGITS: assembled code; first digit in the MSB nibble.
- `Enter_PSW` out 1: one-cycle submit strobe.
- `CT_DN` out 1: one-cycle countdown-start request.
- `digit_cnt` out 3: digits held, 0..DIGITS.
- `busy` out 1: high in any state other than IDLE.
- `reject` out 1: one-cycle pulse; enter pressed with a short entry.
- `abort` out 1: one-cycle pulse; inactivity timeout.

## Operation
- **Reset values:** state IDLE, `passcode`=0, `digit_cnt`=0, timeout and hold counters 0, all pulse outputs 0.
- **IDLE**
  - `key_valid` → shift the digit in, `digit_cnt`=1, pulse `CT_DN`, go to COLLECT.
  - `key_clear`, `key_enter` and `sec_tick` are ignored.
- **COLLECT**
  - `key_valid` → `passcode` <= {passcode[4*DIGITS-5:0], key_code}, `digit_cnt`+1, timeout counter cleared.
  - When `digit_cnt` reaches DIGITS → go to FULL.
  - `key_enter` → pulse `reject`; stay in COLLECT with digits kept.
- **FULL**
  - `key_valid` is ignored: no shift, no counter change, timeout counter not cleared.
  - `key_enter` → go to SEND.
- **SEND** (exactly 1 cycle)
  - `Enter_PSW`=1 with `passcode` stable.
  - Go to HOLD.
- **HOLD**
  - `passcode` is held for HOLD_CYC cycles; all keys are ignored.
  - Then clear `passcode` and `digit_cnt`, go to IDLE.
- **Clear:** in COLLECT or FULL, `key_clear` → zero `passcode` and `digit_cnt`, go to IDLE, no pulse.
- **Timeout:** in COLLECT or FULL, `sec_tick` increments the timeout counter. When the counter reaches TIMEOUT_S → pulse `abort`, clear as for `key_clear`, go to IDLE.
- **Same-cycle priority:** `key_clear` > `key_enter` > `key_valid` > `sec_tick`.
  - A key accepted in the same cycle as `sec_tick` clears the timeout counter; the tick is lost.
  - `key_enter` together with `key_valid` in COLLECT: enter is evaluated against the pre-update `digit_cnt` and the digit is dropped.
- **Reset mid-operation:** returns immediately to the reset values. No `Enter_PSW` or `abort` is emitted.
- **Widths:**
  - Timeout counter is $clog2(TIMEOUT_S+1) bits.
  - Hold counter is $clog2(HOLD_CYC+1) bits.
  - `digit_cnt` saturates at DIGITS; it never wraps.

## Timing
- All outputs are registered.
- `CT_DN` is high in the cycle after the first `key_valid`.
- `Enter_PSW` is high exactly one cycle: the cycle after `key_enter` is sampled in FULL.
- `passcode` is valid from the cycle after the last digit. It stays stable through SEND and HOLD: HOLD_CYC+1 cycles including the strobe.
- `reject` and `abort` are each one cycle, in the cycle after the cause.
- `busy` rises with `CT_DN` and falls in the first IDLE cycle.
- Input pulses longer than one cycle are treated as repeated events. A repeated `key_enter` in SEND or HOLD is ignored.

## Structure
- Shared package `safe_vault_pkg`:
  - `entry_state_t` enum {IDLE, COLLECT, FULL, SEND, HOLD}.
  - `PSW_W` = 16 and `DIGITS_DEF` = 4.
  - Default TIMEOUT_S of 5, matching the vault's countdown window.
- One sub-module is natural: `tick_counter`, a loadable saturating counter with clear, enable and a terminal flag. It is instantiated twice, once for the timeout and once for the hold.

## Test plan
- **Correct code:** keys E,4,6,9 then enter.
  - `CT_DN` pulses once after E; `digit_cnt` goes 1,2,3,4.
  - `passcode`=16'hE469 at the `Enter_PSW` strobe, held 5 cycles, then 0 and `busy`=0.
- **Short entry and overflow:** keys 1,2 then enter → `reject` pulse, `digit_cnt`=2. Then 3,4,5 → after 3,4 `digit_cnt`=4, `passcode`=16'h1234, and 5 is ignored. Enter → `Enter_PSW` with 16'h1234.
- **Timeout:** key A, then 5 `sec_tick`s with no key → `abort` on the 5th tick (+1 cycle), `passcode`=0, IDLE. A 4-tick gap followed by a key does not abort.
- **Clear priority:** in FULL, drive `key_clear`, `key_enter` and `key_valid` in the same cycle → no `Enter_PSW`, IDLE, `passcode`=0.
- **Async reset in HOLD:** drop `reset_n` between clock edges → outputs zero immediately. After release, a new entry of 0,0,0,1 produces 16'h0001.
- **HOLD lockout:** keys pressed during HOLD → `passcode` is unchanged and there is no second `CT_DN` until IDLE.
